// File: rtl/keypad_event_scanner_pkg.sv
// Shared types and constants for the keypad event scanner: event record, pad key indices
// and the key-code width helper.
package keypad_pkg;

   localparam int KEY_CODE_W = 4;
   localparam int KEY_STAR   = 10;
   localparam int KEY_SHARP  = 11;

   // "release" is a reserved word, so the release flag is called is_release.
   typedef struct packed {
      logic                  is_release;
      logic [KEY_CODE_W-1:0] code;
   } key_evt_t;

   function automatic int code_width(input int num_keys);
      return (num_keys > 1) ? $clog2(num_keys) : 1;
   endfunction

endpackage

// File: rtl/keypad_event_scanner_if.sv
// Event stream between the keypad scanner (master) and its consumer (slave).
interface keypad_event_scanner_if
   import keypad_pkg::*;
#(
   parameter int CODE_W = KEY_CODE_W
) ();

   // valid/ready: master holds evt_valid/evt_code/evt_release stable until the consumer
   // takes the event on a clock edge where evt_valid && evt_ready; ready may depend on valid.
   logic              evt_valid;
   logic              evt_ready;
   logic [CODE_W-1:0] evt_code;
   logic              evt_release;

   modport master (output evt_valid, output evt_code, output evt_release, input evt_ready);
   modport slave  (input evt_valid, input evt_code, input evt_release, output evt_ready);

endinterface

// File: rtl/keypad_event_scanner_fifo.sv
// DEPTH-entry event queue with same-edge push/pop; head is zero whenever the queue is empty.
module key_event_fifo
   import keypad_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push_i,
   input  key_evt_t push_data_i,
   input  logic     pop_i,
   output key_evt_t head_o,
   output logic     valid_o,
   output logic     full_o
);

   localparam int AW = $clog2(DEPTH);

   key_evt_t    mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        empty;
   logic        do_pop;
   logic        do_push;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i && !empty;
   assign do_push = push_i && (!full_o || do_pop);

   assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
   assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

   assign valid_o = !empty;
   assign head_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/keypad_event_scanner.sv
// Keypad front end: synchronise raw keys, scan and debounce them round-robin, queue
// press/release events, and keep a registered direct-select tap for legacy consumers.
module keypad_event_scanner
   import keypad_pkg::*;
#(
   parameter int NUM_KEYS       = 12,
   parameter int CODE_W         = KEY_CODE_W,
   parameter int HIST           = 3,
   parameter int SCAN_DIV       = 1,
   parameter int DEPTH          = 4,
   parameter bit REPORT_RELEASE = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [NUM_KEYS-1:0] key_in,
   input  logic [CODE_W-1:0]   dir_sel,
   output logic                dir_out,
   output logic [NUM_KEYS-1:0] pressed,
   output logic                overflow,
   input  logic                ovf_clr,
   keypad_event_scanner_if.master evt
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [NUM_KEYS-1:0] sync1_q, sync2_q;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [CODE_W-1:0]   idx_q, idx_d;
   logic [HIST-1:0]     hist_q [NUM_KEYS];
   logic [HIST-1:0]     hist_d [NUM_KEYS];
   logic [NUM_KEYS-1:0] pressed_q, pressed_d;
   logic                dir_q, dir_d;
   logic                ovf_q, ovf_d;

   logic            step;
   logic [HIST-1:0] sample_hist;
   logic            push_req;
   key_evt_t        push_evt;
   key_evt_t        head;
   logic            fifo_valid;
   logic            fifo_full;
   logic            pop;

   assign step = enable && (div_q == DIV_W'(SCAN_DIV - 1));

   // One key is visited per step, so at most one event can appear per clock.
   always_comb begin
      div_d       = div_q;
      idx_d       = idx_q;
      hist_d      = hist_q;
      pressed_d   = pressed_q;
      sample_hist = '0;
      push_req    = 1'b0;
      push_evt    = '0;
      if (enable) begin
         div_d = step ? '0 : div_q + 1'b1;
      end
      if (step) begin
         sample_hist        = hist_q[idx_q] << 1;
         sample_hist[0]     = sync2_q[idx_q];
         hist_d[idx_q]      = sample_hist;
         push_evt.code      = KEY_CODE_W'(idx_q);
         if (&sample_hist && !pressed_q[idx_q]) begin
            pressed_d[idx_q]    = 1'b1;
            push_req            = 1'b1;
         end else if (~|sample_hist && pressed_q[idx_q]) begin
            pressed_d[idx_q]    = 1'b0;
            push_req            = REPORT_RELEASE;
            push_evt.is_release = 1'b1;
         end
         idx_d = (idx_q == CODE_W'(NUM_KEYS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   // Out-of-range selects match no key and read as 0.
   always_comb begin
      dir_d = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (dir_sel == CODE_W'(k)) begin
            dir_d = sync2_q[k];
         end
      end
   end

   assign pop   = fifo_valid && evt.evt_ready;
   // A drop in the same cycle as ovf_clr keeps the flag set.
   assign ovf_d = (ovf_clr ? 1'b0 : ovf_q) | (push_req && fifo_full && !pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         div_q     <= '0;
         idx_q     <= '0;
         pressed_q <= '0;
         dir_q     <= 1'b0;
         ovf_q     <= 1'b0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            hist_q[k] <= '0;
         end
      end else begin
         sync1_q   <= key_in;
         sync2_q   <= sync1_q;
         div_q     <= div_d;
         idx_q     <= idx_d;
         pressed_q <= pressed_d;
         dir_q     <= dir_d;
         ovf_q     <= ovf_d;
         hist_q    <= hist_d;
      end
   end

   key_event_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push_req),
      .push_data_i (push_evt),
      .pop_i       (pop),
      .head_o      (head),
      .valid_o     (fifo_valid),
      .full_o      (fifo_full)
   );

   assign evt.evt_valid   = fifo_valid;
   assign evt.evt_code    = CODE_W'(head.code);
   assign evt.evt_release = head.is_release;
   assign pressed         = pressed_q;
   assign overflow        = ovf_q;
   assign dir_out         = dir_q;

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Bench for keypad_event_scanner: a sample-run/queue model checked every cycle, plus
// directed scenarios with hand-derived expectations and a press-only instance.
module tb_keypad_event_scanner;
   import keypad_pkg::*;

   localparam int NK       = 12;
   localparam int CW       = 4;
   localparam int HIST     = 3;
   localparam int SCAN_DIV = 1;
   localparam int DEPTH    = 4;
   localparam bit RR       = 1'b1;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          enable  = 1'b0;
   logic          ovf_clr = 1'b0;
   logic [NK-1:0] key_in  = '0;
   logic [CW-1:0] dir_sel = '0;
   logic          dir_out;
   logic [NK-1:0] pressed;
   logic          overflow;
   keypad_event_scanner_if #(.CODE_W(CW)) evt_if ();

   logic [NK-1:0] key_nr = '0;
   logic          dir_out_nr;
   logic [NK-1:0] pressed_nr;
   logic          overflow_nr;
   keypad_event_scanner_if #(.CODE_W(CW)) nr_if ();

   int checks = 0;
   int errors = 0;

   keypad_event_scanner #(
      .NUM_KEYS(NK), .CODE_W(CW), .HIST(HIST), .SCAN_DIV(SCAN_DIV), .DEPTH(DEPTH),
      .REPORT_RELEASE(1'b1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .key_in(key_in), .dir_sel(dir_sel),
      .dir_out(dir_out), .pressed(pressed), .overflow(overflow), .ovf_clr(ovf_clr),
      .evt(evt_if)
   );

   keypad_event_scanner #(
      .NUM_KEYS(NK), .CODE_W(CW), .HIST(HIST), .SCAN_DIV(SCAN_DIV), .DEPTH(DEPTH),
      .REPORT_RELEASE(1'b0)
   ) u_dut_nr (
      .clk(clk), .rst_n(rst_n), .enable(enable), .key_in(key_nr), .dir_sel(dir_sel),
      .dir_out(dir_out_nr), .pressed(pressed_nr), .overflow(overflow_nr), .ovf_clr(1'b0),
      .evt(nr_if)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Debounce is modelled as run lengths of identical samples per key; the FIFO as a queue.
   int unsigned   m_en_cnt = 0;
   int unsigned   m_steps  = 0;
   logic [NK-1:0] m_s1 = '0, m_s2 = '0, m_pressed = '0;
   int            m_run_len [NK];
   logic          m_run_val [NK];
   logic          m_ovf = 1'b0, m_dir = 1'b0;
   logic [CW:0]   exp_q[$];
   logic [CW:0]   got_q[$];

   function automatic void model_reset();
      m_en_cnt  = 0;
      m_steps   = 0;
      m_s1      = '0;
      m_s2      = '0;
      m_pressed = '0;
      m_ovf     = 1'b0;
      m_dir     = 1'b0;
      exp_q.delete();
      for (int k = 0; k < NK; k++) begin
         m_run_val[k] = 1'b0;
         m_run_len[k] = HIST;
      end
   endfunction

   function automatic void model_step();
      int          k;
      logic        b;
      logic        ev;
      logic [CW:0] ev_word;
      ev      = 1'b0;
      ev_word = '0;
      if (int'(dir_sel) < NK) m_dir = m_s2[dir_sel];
      else                    m_dir = 1'b0;
      if (enable) begin
         if (m_en_cnt % SCAN_DIV == SCAN_DIV - 1) begin
            k = int'(m_steps % NK);
            b = m_s2[k];
            if (b == m_run_val[k]) begin
               if (m_run_len[k] < HIST) m_run_len[k]++;
            end else begin
               m_run_val[k] = b;
               m_run_len[k] = 1;
            end
            if (m_run_len[k] >= HIST && m_run_val[k] != m_pressed[k]) begin
               m_pressed[k] = m_run_val[k];
               if (m_run_val[k] || RR) begin
                  ev      = 1'b1;
                  ev_word = {~m_run_val[k], CW'(k)};
               end
            end
            m_steps++;
         end
         m_en_cnt++;
      end
      if (evt_if.evt_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (ovf_clr) m_ovf = 1'b0;
      if (ev) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(ev_word);
         else                      m_ovf = 1'b1;
      end
      m_s2 = m_s1;
      m_s1 = key_in;
   endfunction

   // Will the coming clock edge generate an event (judged from the model only)?
   function automatic bit predict_event();
      int   k;
      int   len;
      logic b;
      if (!enable || (m_en_cnt % SCAN_DIV != SCAN_DIV - 1)) return 1'b0;
      k   = int'(m_steps % NK);
      b   = m_s2[k];
      len = (b == m_run_val[k]) ? m_run_len[k] + 1 : 1;
      return (len >= HIST) && (b != m_pressed[k]) && (b || RR);
   endfunction

   initial model_reset();

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // One compare per cycle of the whole observable output bundle.
   always @(negedge clk) begin
      logic        v;
      logic [CW:0] head;
      v    = (exp_q.size() > 0);
      head = v ? exp_q[0] : '0;
      check("cycle",
            32'({evt_if.evt_valid, evt_if.evt_release, evt_if.evt_code, pressed, overflow, dir_out}),
            32'({v, head, m_pressed, m_ovf, m_dir}));
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_evt(output bit found);
      found = 1'b0;
      for (int i = 0; i < 41 && !found; i++) begin
         tick(1);
         if (evt_if.evt_valid) found = 1'b1;
      end
   endtask

   task automatic pop_one();
      evt_if.evt_ready = 1'b1;
      tick(1);
      evt_if.evt_ready = 1'b0;
   endtask

   task automatic drain(input int budget);
      got_q.delete();
      evt_if.evt_ready = 1'b1;
      for (int i = 0; i < budget && evt_if.evt_valid; i++) begin
         got_q.push_back({evt_if.evt_release, evt_if.evt_code});
         tick(1);
      end
      evt_if.evt_ready = 1'b0;
   endtask

   task automatic expect_drain(input string tag, input logic [4*(CW+1)-1:0] want);
      check({tag, "_count"}, 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check({tag, "_order"}, 32'((got_q.size() > i) ? got_q[i] : '1),
               32'(want[(3-i)*(CW+1) +: (CW+1)]));
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bit found;
      bit hit;
      bit seen;
      evt_if.evt_ready = 1'b0;
      nr_if.evt_ready  = 1'b0;
      tick(3);
      check("reset_valid", 32'(evt_if.evt_valid), 32'd0);
      check("reset_pressed", 32'(pressed), 32'd0);
      rst_n  = 1'b1;
      enable = 1'b1;
      tick(2);

      // Press / release of key 4 with default parameters.
      key_in[4] = 1'b1;
      wait_evt(found);
      check("press4_latency", 32'(found), 32'd1);
      check("press4_event", 32'({evt_if.evt_release, evt_if.evt_code}), 32'h04);
      check("press4_pressed", 32'(pressed[4]), 32'd1);
      pop_one();
      tick(45);
      check("press4_single", 32'(evt_if.evt_valid), 32'd0);
      key_in[4] = 1'b0;
      wait_evt(found);
      check("release4_latency", 32'(found), 32'd1);
      check("release4_event", 32'({evt_if.evt_release, evt_if.evt_code}), 32'h14);
      check("release4_pressed", 32'(pressed[4]), 32'd0);
      pop_one();

      // Bounce: a toggle period of twice the scan round means each visit sees the other level.
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         key_in[10] = ~key_in[10];
         for (int j = 0; j < 12; j++) begin
            tick(1);
            seen = seen | evt_if.evt_valid;
         end
      end
      check("bounce_quiet", 32'(seen), 32'd0);
      key_in[10] = 1'b1;
      wait_evt(found);
      check("bounce_press", 32'({found, evt_if.evt_release, evt_if.evt_code}), 32'h2A);
      pop_one();
      tick(45);
      check("bounce_single", 32'(evt_if.evt_valid), 32'd0);

      // Overflow: six events into a four-deep queue with the consumer stalled.
      for (int k = 0; k < 3; k++) begin
         key_in[k] = 1'b1;
         tick(45);
         key_in[k] = 1'b0;
         tick(45);
      end
      check("ovf_set", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      check("ovf_clr", 32'(overflow), 32'd0);
      drain(10);
      expect_drain("ovf_drain", {5'h00, 5'h10, 5'h01, 5'h11});

      // Full queue plus a pop on the very edge that produces a new event.
      key_in[3] = 1'b1; tick(45);
      key_in[3] = 1'b0; tick(45);
      key_in[5] = 1'b1; tick(45);
      key_in[5] = 1'b0; tick(45);
      check("full_no_ovf", 32'(overflow), 32'd0);
      key_in[6] = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         if (predict_event()) begin
            evt_if.evt_ready = 1'b1;
            tick(1);
            evt_if.evt_ready = 1'b0;
            hit = 1'b1;
         end else begin
            tick(1);
         end
      end
      check("full_pop_aligned", 32'(hit), 32'd1);
      tick(2);
      check("full_pop_ovf", 32'(overflow), 32'd0);
      drain(10);
      expect_drain("full_pop_drain", {5'h13, 5'h05, 5'h15, 5'h06});

      // Direct-select path and frozen scan.
      evt_if.evt_ready = 1'b1;
      dir_sel    = 4'd11;
      key_in[11] = 1'b1;
      tick(2);
      check("dir_lat2", 32'(dir_out), 32'd0);
      tick(1);
      check("dir_lat3", 32'(dir_out), 32'd1);
      dir_sel = 4'd13;
      tick(1);
      check("dir_out_of_range", 32'(dir_out), 32'd0);
      tick(45);
      key_in[11] = 1'b0;
      tick(45);
      evt_if.evt_ready = 1'b0;
      enable    = 1'b0;
      dir_sel   = 4'd9;
      key_in[9] = 1'b1;
      tick(50);
      check("frozen_no_event", 32'({evt_if.evt_valid, pressed[9]}), 32'd0);
      check("frozen_dir_live", 32'(dir_out), 32'd1);
      enable = 1'b1;
      wait_evt(found);
      check("unfrozen_press", 32'({found, evt_if.evt_release, evt_if.evt_code}), 32'h29);
      evt_if.evt_ready = 1'b1;
      key_in[9] = 1'b0;
      tick(45);
      evt_if.evt_ready = 1'b0;

      // Press-only instance: release changes state but queues nothing.
      key_nr[2] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 41 && !found; i++) begin
         tick(1);
         if (nr_if.evt_valid) found = 1'b1;
      end
      check("nr_press", 32'({found, nr_if.evt_release, nr_if.evt_code}), 32'h22);
      nr_if.evt_ready = 1'b1;
      tick(1);
      nr_if.evt_ready = 1'b0;
      key_nr[2] = 1'b0;
      tick(45);
      check("nr_no_release", 32'(nr_if.evt_valid), 32'd0);
      check("nr_pressed_clear", 32'(pressed_nr[2]), 32'd0);

      // Asynchronous reset mid-scan with two events queued.
      key_in[7] = 1'b1;
      key_in[8] = 1'b1;
      tick(45);
      check("pre_reset_queued", 32'({evt_if.evt_valid, pressed[8:7]}), 32'h7);
      @(posedge clk);
      #3;
      rst_n  = 1'b0;
      key_in = '0;
      #1;
      check("async_reset_outputs",
            32'({evt_if.evt_valid, evt_if.evt_release, evt_if.evt_code, pressed, overflow, dir_out}),
            32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(60);
      check("post_reset_empty", 32'(evt_if.evt_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
